// File: rtl/wishbone_rr_arbiter_if.sv
// Bundles the signals of a wishbone_rr_arbiter. The masters' side is m_*,
// the shared slave bus is s_*, and arbitration status is grant/busy.
//   arb    : the arbiter's view (m_*_i and s_*_i in; m_*_o, s_*_o, grant and busy out)
//   master : the requesting masters' view
//   slave  : the decoded slave bus view
// The m_adr_i, m_dat_i and m_sel_i vectors are packed, with master i at slice i.
interface wishbone_rr_arbiter_if #(
    parameter int NUM_MASTERS  = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4
);
    logic [NUM_MASTERS-1:0]              m_cyc_i;
    logic [NUM_MASTERS-1:0]              m_stb_i;
    logic [NUM_MASTERS-1:0]              m_we_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i;
    logic [NUM_MASTERS*SELECT_WIDTH-1:0] m_sel_i;
    logic [DATA_WIDTH-1:0]               m_dat_o;
    logic [NUM_MASTERS-1:0]              m_ack_o;
    logic [NUM_MASTERS-1:0]              m_err_o;
    logic [NUM_MASTERS-1:0]              m_rty_o;

    logic                                s_cyc_o;
    logic                                s_stb_o;
    logic                                s_we_o;
    logic [ADDR_WIDTH-1:0]               s_adr_o;
    logic [DATA_WIDTH-1:0]               s_dat_o;
    logic [SELECT_WIDTH-1:0]             s_sel_o;
    logic [DATA_WIDTH-1:0]               s_dat_i;
    logic                                s_ack_i;
    logic                                s_err_i;
    logic                                s_rty_i;

    logic [NUM_MASTERS-1:0]              grant;
    logic                                busy;

    modport arb (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output grant, busy
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o, grant, busy
    );

    modport slave (
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );
endinterface

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter that lets NUM_MASTERS wishbone masters share a single
// slave bus. A master owns the bus for its whole cyc tenure. Between tenures
// there is always one IDLE cycle. A watchdog turns a strobe that no slave
// terminates within TIMEOUT clocks into a bus error for the owner.
// Ports:
//   clk_i : bus clock; all state changes on the rising edge
//   reset : asynchronous, active-high
//   bus   : wishbone_rr_arbiter_if.arb, which carries the master side,
//           the slave side, grant (one-hot owner) and busy
module wishbone_rr_arbiter #(
    parameter int NUM_MASTERS  = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk_i,
    input  logic                 reset,
    wishbone_rr_arbiter_if.arb   bus
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic { IDLE, OWNED } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [WD_W-1:0]        wd_q, wd_d;

    logic [IDX_W-1:0]       owner;
    logic                   own_cyc, own_stb, term, abort, found;

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (grant_q[i]) owner = IDX_W'(i);
    end

    assign own_cyc = |(grant_q & bus.m_cyc_i);
    assign own_stb = |(grant_q & bus.m_stb_i);
    assign term    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

    // Any termination in the limit cycle takes precedence over the abort.
    // That way a late ack is still delivered and does not become an error.
    generate
        if (TIMEOUT > 0) begin : g_wd
            assign abort = (state_q == OWNED) && own_stb && !term &&
                           (wd_q == WD_W'(TIMEOUT));
        end else begin : g_nowd
            assign abort = 1'b0;
        end
    endgenerate

    // Slave side is an AND-OR mux keyed by grant. An idle or reset arbiter
    // therefore drives all zeros with no extra gating.
    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.s_adr_o = bus.s_adr_o |
                ({ADDR_WIDTH{grant_q[i]}}   & bus.m_adr_i[i*ADDR_WIDTH   +: ADDR_WIDTH]);
            bus.s_dat_o = bus.s_dat_o |
                ({DATA_WIDTH{grant_q[i]}}   & bus.m_dat_i[i*DATA_WIDTH   +: DATA_WIDTH]);
            bus.s_sel_o = bus.s_sel_o |
                ({SELECT_WIDTH{grant_q[i]}} & bus.m_sel_i[i*SELECT_WIDTH +: SELECT_WIDTH]);
        end
    end

    assign bus.s_cyc_o = own_cyc;
    assign bus.s_stb_o = own_stb & ~abort;
    assign bus.s_we_o  = |(grant_q & bus.m_we_i);

    // Terminations return only to the owner, and only while it strobes.
    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_resp
            assign bus.m_ack_o[i] = grant_q[i] & bus.m_stb_i[i] & bus.s_ack_i & ~abort;
            assign bus.m_rty_o[i] = grant_q[i] & bus.m_stb_i[i] & bus.s_rty_i & ~abort;
            assign bus.m_err_o[i] = grant_q[i] & ((bus.m_stb_i[i] & bus.s_err_i) | abort);
        end
    endgenerate

    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q == OWNED);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wd_d    = '0;
        found   = 1'b0;
        case (state_q)
            IDLE: begin
                // The search starts just after the previous owner. That owner
                // wins again only when nobody else is asking.
                for (int k = 1; k <= NUM_MASTERS; k++) begin
                    if (!found && bus.m_cyc_i[(int'(last_q) + k) % NUM_MASTERS]) begin
                        found   = 1'b1;
                        grant_d = '0;
                        grant_d[(int'(last_q) + k) % NUM_MASTERS] = 1'b1;
                    end
                end
                if (found) state_d = OWNED;
            end
            OWNED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner;
                end else if (TIMEOUT > 0 && own_stb && !term && !abort) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end
endmodule
